uart_boot_loader: RTL and testbench

- Upstream of the single-cycle RISC-V core.
- Receives a program image over a UART serial line, assembles little-endian 32-bit words and writes them into the instruction memory write port.
- Holds the core in reset until a complete image with a valid checksum has been loaded, then releases it.
- One clock domain; the only asynchronous input is the serial line.

---
 rtl/boot_pkg.sv | 25 ++
 rtl/uart_rx.sv | 109 ++++++++++
 rtl/uart_boot_loader.sv | 152 +++++++++++++++
 tb/tb_uart_boot_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// Frame FSM states, receiver states and protocol constants.
package boot_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
  localparam int         FRAME_BITS    = 10;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer, shift register.
// byteValid pulses one cycle after the stop-bit sample.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       frameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  logic          s1, s2;
  rx_state_t     rs, rs_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitIdx, bitIdx_n;
  logic [7:0]    sh, sh_n;
  logic          bv_n, fe_n;
  logic [7:0]    bd_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs        <= RX_IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      sh        <= '0;
      byteValid <= 1'b0;
      byteData  <= '0;
      frameErr  <= 1'b0;
    end else begin
      rs        <= rs_n;
      cnt       <= cnt_n;
      bitIdx    <= bitIdx_n;
      sh        <= sh_n;
      byteValid <= bv_n;
      byteData  <= bd_n;
      frameErr  <= fe_n;
    end
  end

  always_comb begin
    rs_n     = rs;
    cnt_n    = cnt;
    bitIdx_n = bitIdx;
    sh_n     = sh;
    bv_n     = 1'b0;
    bd_n     = byteData;
    fe_n     = frameErr;
    unique case (rs)
      RX_IDLE: begin
        if (!s2) begin
          rs_n  = RX_START;
          cnt_n = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_n    = '0;
          bitIdx_n = '0;
          // line back high at mid start bit: treat as a glitch
          rs_n     = s2 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n    = '0;
          sh_n     = {s2, sh[7:1]};
          bitIdx_n = bitIdx + 1'b1;
          if (bitIdx == LAST_BIT) rs_n = RX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          bv_n  = 1'b1;
          bd_n  = sh;
          fe_n  = !s2;
          rs_n  = RX_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: rs_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a checksummed program image from UART into instruction memory,
// holding the core in reset until the image is accepted.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         IMEM_WORDS   = 256,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic        imemWe,
  output logic [7:0]  imemAddr,
  output logic [31:0] imemWdata,
  output logic        coreReset,
  output logic        loadDone,
  output logic        loadError
);

  localparam logic [16:0] MAXW = 17'(IMEM_WORDS);

  logic        byteValid;
  logic [7:0]  byteData;
  logic        frameErr;

  boot_state_t state, st_n;
  logic [7:0]  lenLo, lenLo_n;
  logic [7:0]  lastIdx, lastIdx_n;
  logic [1:0]  byteCnt, byteCnt_n;
  logic [7:0]  wordIdx, wordIdx_n;
  logic [7:0]  csum, csum_n;
  logic [31:0] word, word_n, asm;
  logic        we_n;
  logic [7:0]  addr_n;
  logic [31:0] wdata_n;
  logic [15:0] lenN;
  logic        lenBad;
  logic        isSync;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .byteValid(byteValid),
    .byteData (byteData),
    .frameErr (frameErr)
  );

  assign lenN   = {byteData, lenLo};
  assign lenBad = (lenN == 16'd0) || ({1'b0, lenN} > MAXW);
  assign isSync = !frameErr && (byteData == SYNC_BYTE);

  always_comb begin
    asm = word;
    asm[{byteCnt, 3'b000} +: 8] = byteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SYNC;
      lenLo     <= '0;
      lastIdx   <= '0;
      byteCnt   <= '0;
      wordIdx   <= '0;
      csum      <= '0;
      word      <= '0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWdata <= '0;
      coreReset <= 1'b1;
      loadDone  <= 1'b0;
      loadError <= 1'b0;
    end else begin
      state     <= st_n;
      lenLo     <= lenLo_n;
      lastIdx   <= lastIdx_n;
      byteCnt   <= byteCnt_n;
      wordIdx   <= wordIdx_n;
      csum      <= csum_n;
      word      <= word_n;
      imemWe    <= we_n;
      imemAddr  <= addr_n;
      imemWdata <= wdata_n;
      coreReset <= (st_n != S_DONE);
      loadDone  <= (st_n == S_DONE);
      loadError <= (st_n == S_ERROR);
    end
  end

  always_comb begin
    st_n      = state;
    lenLo_n   = lenLo;
    lastIdx_n = lastIdx;
    byteCnt_n = byteCnt;
    wordIdx_n = wordIdx;
    csum_n    = csum;
    word_n    = word;
    we_n      = 1'b0;
    addr_n    = imemAddr;
    wdata_n   = imemWdata;
    if (byteValid) begin
      unique case (state)
        S_SYNC: begin
          if (isSync) st_n = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (frameErr) begin
            st_n = S_ERROR;
          end else begin
            lenLo_n = byteData;
            st_n    = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          byteCnt_n = '0;
          wordIdx_n = '0;
          csum_n    = '0;
          lastIdx_n = 8'(lenN - 16'd1);
          st_n      = (frameErr || lenBad) ? S_ERROR : S_LOAD;
        end
        S_LOAD: begin
          if (frameErr) begin
            st_n = S_ERROR;
          end else begin
            word_n    = asm;
            csum_n    = csum ^ byteData;
            byteCnt_n = byteCnt + 1'b1;
            if (byteCnt == 2'd3) begin
              we_n      = 1'b1;
              addr_n    = wordIdx;
              wdata_n   = asm;
              wordIdx_n = wordIdx + 1'b1;
              if (wordIdx == lastIdx) st_n = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          st_n = (!frameErr && byteData == csum) ? S_DONE : S_ERROR;
        end
        S_DONE: st_n = S_DONE;
        S_ERROR: begin
          if (isSync) st_n = S_LEN_LO;
        end
        default: st_n = S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a byte-stream parser model
// and a per-cycle compare of write strobes and status flags.
module tb_uart_boot_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic        imemWe;
  logic [7:0]  imemAddr;
  logic [31:0] imemWdata;
  logic        coreReset;
  logic        loadDone;
  logic        loadError;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .imemWe   (imemWe),
    .imemAddr (imemAddr),
    .imemWdata(imemWdata),
    .coreReset(coreReset),
    .loadDone (loadDone),
    .loadError(loadError)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  tx[$];
  int          nvec = 0;
  int          nerr = 0;
  bit          settled = 1'b0;
  bit          exp_done = 1'b0;
  bit          exp_err = 1'b0;
  bit          m_done, m_err;
  int          wr_count = 0;
  logic [7:0]  last_a = '0;
  logic [31:0] last_d = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (imemWe) begin
        wr_count++;
        last_a = imemAddr;
        last_d = imemWdata;
        if (exp_q.size() == 0) begin
          check("spurious_write", exp_q.size(), 1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("waddr", imemAddr, e.a);
          check("wdata", imemWdata, e.d);
        end
      end
      if (settled) begin
        check("loadDone", loadDone, exp_done);
        check("loadError", loadError, exp_err);
        check("coreReset", coreReset, !exp_done);
      end
    end
  end

  // Parse the whole byte list: expected writes and final flags.
  task automatic model_frame(input int fault);
    int i = 0;
    int n;
    int p;
    logic [7:0] c = '0;
    logic [31:0] d;
    m_done = exp_done;
    m_err  = exp_err;
    while (i < tx.size() && !(tx[i] == 8'h55 && i != fault)) i++;
    if (i >= tx.size()) return;
    m_err = 1'b0;
    if (i + 2 >= tx.size()) return;
    if (fault == i + 1 || fault == i + 2) begin
      m_err = 1'b1;
      return;
    end
    n = {tx[i+2], tx[i+1]};
    if (n == 0 || n > 256) begin
      m_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        p = i + 3 + 4 * w + k;
        if (p >= tx.size()) return;
        if (p == fault) begin
          m_err = 1'b1;
          return;
        end
        d[8*k +: 8] = tx[p];
        c = c ^ tx[p];
      end
      exp_q.push_back({8'(w), d});
    end
    p = i + 3 + 4 * n;
    if (p >= tx.size()) return;
    if (p == fault || tx[p] != c) m_err = 1'b1;
    else m_done = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = !bad_stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    if (bad_stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    exp_done = m_done;
    exp_err  = m_err;
    settled  = 1'b1;
  endtask

  task automatic send_frame(input int fault, input int glitch);
    settled = 1'b0;
    model_frame(fault);
    for (int i = 0; i < tx.size(); i++) begin
      if (i == glitch) begin
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
      end
      send_byte(tx[i], i == fault);
    end
    settle();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #3 reset = 1'b1;
    rxd = 1'b1;
    #1;
    check({tag, "_coreReset"}, coreReset, 1);
    check({tag, "_loadDone"}, loadDone, 0);
    check({tag, "_loadError"}, loadError, 0);
    check({tag, "_imemWe"}, imemWe, 0);
    check({tag, "_imemAddr"}, imemAddr, 0);
    check({tag, "_imemWdata"}, imemWdata, 0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_q.delete();
    wr_count = 0;
    settled  = 1'b1;
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) tx.push_back(w[8*k +: 8]);
  endtask

  task automatic add_hdr(input logic [15:0] n);
    tx.push_back(8'h55);
    tx.push_back(n[7:0]);
    tx.push_back(n[15:8]);
  endtask

  task automatic add_csum(input int from);
    logic [7:0] c = '0;
    for (int i = from; i < tx.size(); i++) c = c ^ tx[i];
    tx.push_back(c);
  endtask

  task automatic mk_single(input logic [7:0] ck);
    tx.delete();
    add_hdr(16'd1);
    add_word(32'hDEADBEEF);
    tx.push_back(ck);
  endtask

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    do_reset("init");

    // single word
    mk_single(8'h22);
    send_frame(-1, -1);
    check("single_count", wr_count, 1);
    check("single_addr", last_a, 8'h00);
    check("single_data", last_d, 32'hDEADBEEF);
    check("single_done", loadDone, 1);
    check("single_corerst", coreReset, 0);

    // bad checksum, then resend
    do_reset("badck");
    mk_single(8'h23);
    send_frame(-1, -1);
    check("badck_count", wr_count, 1);
    check("badck_err", loadError, 1);
    check("badck_corerst", coreReset, 1);
    check("badck_done", loadDone, 0);
    mk_single(8'h22);
    settled = 1'b0;
    model_frame(-1);
    send_byte(tx[0], 1'b0);
    repeat (4) @(negedge clk);
    check("err_clear_on_sync", loadError, 0);
    for (int i = 1; i < tx.size(); i++) send_byte(tx[i], 1'b0);
    settle();
    check("resend_count", wr_count, 2);
    check("resend_data", last_d, 32'hDEADBEEF);
    check("resend_done", loadDone, 1);

    // length bounds
    do_reset("len");
    tx.delete();
    add_hdr(16'd0);
    send_frame(-1, -1);
    check("len0_err", loadError, 1);
    tx.delete();
    add_hdr(16'd257);
    send_frame(-1, -1);
    check("len257_err", loadError, 1);
    check("len_writes", wr_count, 0);

    // leading garbage plus idle-line glitch mid payload
    do_reset("glitch");
    tx.delete();
    tx.push_back(8'h00);
    tx.push_back(8'hFF);
    add_hdr(16'd1);
    add_word(32'hDEADBEEF);
    add_csum(5);
    send_frame(-1, 6);
    check("glitch_count", wr_count, 1);
    check("glitch_data", last_d, 32'hDEADBEEF);
    check("glitch_done", loadDone, 1);

    // stop bit low on the last byte of the word
    do_reset("stop");
    mk_single(8'h22);
    send_frame(6, -1);
    check("stop_err", loadError, 1);
    check("stop_writes", wr_count, 0);

    // full image
    do_reset("full");
    tx.delete();
    add_hdr(16'd256);
    for (int w = 0; w < 256; w++) add_word(32'(w * 4));
    add_csum(3);
    send_frame(-1, -1);
    check("full_count", wr_count, 256);
    check("full_last_addr", last_a, 8'hFF);
    check("full_last_data", last_d, 32'h000003FC);
    check("full_done", loadDone, 1);

    // reset mid-load, byte in flight
    do_reset("pre_mid");
    tx.delete();
    add_hdr(16'd4);
    add_word(32'h11111111);
    add_word(32'h22222222);
    tx.push_back(8'h33);
    tx.push_back(8'h33);
    settled = 1'b0;
    model_frame(-1);
    for (int i = 0; i < tx.size(); i++) send_byte(tx[i], 1'b0);
    rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("mid_count", wr_count, 2);
    check("mid_addr", last_a, 8'h01);
    check("mid_pending", exp_q.size(), 0);
    do_reset("mid");
    tx.delete();
    add_hdr(16'd2);
    add_word(32'hAAAA5555);
    add_word(32'h12345678);
    add_csum(3);
    send_frame(-1, -1);
    check("after_count", wr_count, 2);
    check("after_addr", last_a, 8'h01);
    check("after_data", last_d, 32'h12345678);
    check("after_done", loadDone, 1);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
